// File: rtl/sample_dma_ctrl_if.sv
// Sample input, TDSP bus arbitration and sample-RAM DMA signals of sample_dma_ctrl.
interface sample_dma_ctrl_if;
  logic        s_valid;
  logic [15:0] s_data;
  logic        t_grant;
  logic        clr_overflow;
  logic        d_req;
  logic [7:0]  d_addrs;
  logic [15:0] d_datain;
  logic        d_wr;
  logic        frame_done;
  logic        bank;
  logic        overflow;

  modport slave (
    input  s_valid, s_data, t_grant, clr_overflow,
    output d_req, d_addrs, d_datain, d_wr, frame_done, bank, overflow
  );
  modport master (
    output s_valid, s_data, t_grant, clr_overflow,
    input  d_req, d_addrs, d_datain, d_wr, frame_done, bank, overflow
  );
endinterface

// File: rtl/sample_dma_ctrl.sv
// Buffers incoming audio samples and writes them into a two-frame ping-pong
// region of the sample RAM whenever the TDSP is not holding the bus.
module sample_dma_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FRAME_LEN  = 64,
  parameter logic [7:0]  BASE_ADDR  = 8'h00
) (
  input logic              clk,
  input logic              reset,
  sample_dma_ctrl_if.slave bus
);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, WRITE} state_e;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] rptr_q, wptr_q, rptr_p1;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q;
  logic [IW-1:0] idx_q, idx_d;
  logic          wr_bank_q, wr_bank_d;
  logic          d_req_q, frame_done_q, bank_q, overflow_q;
  logic [7:0]    addr_q;
  logic [15:0]   data_q;
  logic          full, push, drop, pop, last;
  logic [15:0]   next_head;

  function automatic logic [7:0] addr_of(input logic b, input logic [IW-1:0] i);
    return BASE_ADDR + (b ? 8'(FRAME_LEN) : 8'h00) + 8'(i);
  endfunction

  // Overflow is judged on occupancy before any same-cycle pop.
  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign push      = bus.s_valid & ~full;
  assign drop      = bus.s_valid & full;
  assign pop       = (state_q == WRITE) & ~bus.t_grant;
  assign cnt_d     = cnt_q + CW'(push) - CW'(pop);
  assign rptr_p1   = rptr_q + PW'(1);
  assign last      = (idx_q == IW'(FRAME_LEN - 1));
  assign idx_d     = last ? '0 : idx_q + IW'(1);
  assign wr_bank_d = wr_bank_q ^ last;
  // With one entry left, the next head is the sample being pushed this cycle.
  assign next_head = (cnt_q == CW'(1)) ? bus.s_data : mem_q[rptr_p1];

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.s_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_q       <= '0;
      wptr_q       <= '0;
      cnt_q        <= '0;
      state_q      <= IDLE;
      idx_q        <= '0;
      wr_bank_q    <= 1'b0;
      d_req_q      <= 1'b0;
      frame_done_q <= 1'b0;
      bank_q       <= 1'b0;
      overflow_q   <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_p1;
      cnt_q   <= cnt_d;
      d_req_q <= (cnt_d != '0);
      if (drop)                  overflow_q <= 1'b1;
      else if (bus.clr_overflow) overflow_q <= 1'b0;
      frame_done_q <= pop & last;
      if (pop & last) bank_q <= wr_bank_q;

      case (state_q)
        IDLE: begin
          if (cnt_q != '0 && !bus.t_grant) begin
            state_q <= SETUP;
            addr_q  <= addr_of(wr_bank_q, idx_q);
            data_q  <= mem_q[rptr_q];
          end
        end
        SETUP: state_q <= bus.t_grant ? IDLE : WRITE;
        WRITE: begin
          if (!bus.t_grant) begin
            idx_q     <= idx_d;
            wr_bank_q <= wr_bank_d;
            if (cnt_d != '0) begin
              state_q <= SETUP;
              addr_q  <= addr_of(wr_bank_d, idx_d);
              data_q  <= next_head;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.d_req      = d_req_q;
  assign bus.d_addrs    = addr_q;
  assign bus.d_datain   = data_q;
  assign bus.d_wr       = (state_q == WRITE) & ~bus.t_grant;
  assign bus.frame_done = frame_done_q;
  assign bus.bank       = bank_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_sample_dma_ctrl.sv
// Directed bench for sample_dma_ctrl with a queue-based reference model checked every cycle.
module tb_sample_dma_ctrl;
  localparam int         DEPTH = 4;
  localparam int         FL    = 64;
  localparam logic [7:0] BASE  = 8'h00;

  logic clk = 1'b0;
  logic reset = 1'b1;
  sample_dma_ctrl_if bus();

  sample_dma_ctrl #(.FIFO_DEPTH(DEPTH), .FRAME_LEN(FL), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pending samples in arrival order, write count since reset.
  logic [15:0] mq[$];
  bit          m_ovf = 0, m_fd = 0, m_bank = 0, m_rstchk = 0, m_live = 0;
  int          wcount = 0, stall = 0;
  logic [7:0]  wl_a[$];
  logic [15:0] wl_d[$];
  bit          fd_b[$];

  function automatic logic [7:0] exp_addr(input int n);
    return 8'(int'(BASE) + ((n / FL) % 2) * FL + (n % FL));
  endfunction

  always @(negedge clk) begin
    bit push_ok, nf;
    if (m_live) begin
      chk("d_req", 32'(bus.d_req), 32'(mq.size() != 0));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("frame_done", 32'(bus.frame_done), 32'(m_fd));
      chk("bank", 32'(bus.bank), 32'(m_bank));
      if (m_rstchk) begin
        chk("rst_addr", 32'(bus.d_addrs), 0);
        chk("rst_data", 32'(bus.d_datain), 0);
        chk("rst_wr", 32'(bus.d_wr), 0);
      end
      if (bus.d_wr) begin
        chk("wr_pending", 32'(mq.size() != 0), 1);
        if (mq.size() != 0) begin
          chk("wr_data", 32'(bus.d_datain), 32'(mq[0]));
          chk("wr_addr", 32'(bus.d_addrs), 32'(exp_addr(wcount)));
        end
      end
      if (!reset && !bus.t_grant && mq.size() != 0 && !bus.d_wr) stall++;
      else stall = 0;
      if (stall == 4) chk("progress_stall", 32'(stall), 3);
    end
    if (bus.d_wr && !reset) begin
      wl_a.push_back(bus.d_addrs);
      wl_d.push_back(bus.d_datain);
    end
    if (bus.frame_done) fd_b.push_back(bus.bank);

    if (reset) begin
      mq.delete();
      m_ovf = 0; m_fd = 0; m_bank = 0; wcount = 0; stall = 0;
      m_rstchk = 1; m_live = 1;
    end else if (m_live) begin
      m_rstchk = 0;
      push_ok = bus.s_valid && (mq.size() < DEPTH);
      if (bus.s_valid && mq.size() == DEPTH) m_ovf = 1;
      else if (bus.clr_overflow)             m_ovf = 0;
      nf = bus.d_wr && (wcount % FL == FL - 1);
      if (nf) m_bank = 1'((wcount / FL) % 2);
      m_fd = nf;
      if (bus.d_wr && mq.size() != 0) begin
        void'(mq.pop_front());
        wcount++;
      end
      if (push_ok) mq.push_back(bus.s_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.s_valid = 1'b0; bus.t_grant = 1'b0; bus.clr_overflow = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic wait_wr(input int target, input int budget, input string name);
    for (int k = 0; k < budget && wl_a.size() < target; k++) cyc();
    if (wl_a.size() < target) begin
      total++; bad++;
      $display("FAIL %s: got %0d writes expected %0d", name, wl_a.size(), target);
    end
  endtask

  initial begin
    int n0, f0;
    bit hit;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.t_grant = 1'b0; bus.clr_overflow = 1'b0;

    // Reset state, then single-sample latency.
    do_reset();
    #1;
    chk("rst_d_req", 32'(bus.d_req), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_frame_done", 32'(bus.frame_done), 0);
    chk("rst_bank", 32'(bus.bank), 0);
    chk("rst_d_addrs", 32'(bus.d_addrs), 0);
    chk("rst_d_datain", 32'(bus.d_datain), 0);
    chk("rst_d_wr", 32'(bus.d_wr), 0);
    bus.s_valid = 1'b1; bus.s_data = 16'hA5A5;
    cyc(); bus.s_valid = 1'b0; #1;
    chk("t1_c1_req", 32'(bus.d_req), 1);  chk("t1_c1_wr", 32'(bus.d_wr), 0);
    cyc(); #1;
    chk("t1_c2_req", 32'(bus.d_req), 1);  chk("t1_c2_wr", 32'(bus.d_wr), 0);
    cyc(); #1;
    chk("t1_c3_req", 32'(bus.d_req), 1);  chk("t1_c3_wr", 32'(bus.d_wr), 1);
    chk("t1_c3_addr", 32'(bus.d_addrs), 32'h00);
    chk("t1_c3_data", 32'(bus.d_datain), 32'hA5A5);
    cyc(); #1;
    chk("t1_c4_req", 32'(bus.d_req), 0);  chk("t1_c4_wr", 32'(bus.d_wr), 0);

    // Overflow while TDSP holds the bus; set beats a same-cycle clear.
    do_reset();
    n0 = wl_a.size();
    bus.t_grant = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.s_valid = 1'b1; bus.s_data = 16'(i); bus.clr_overflow = (i == 5);
      cyc();
    end
    bus.s_valid = 1'b0; bus.clr_overflow = 1'b0; #1;
    chk("t2_ovf_set", 32'(bus.overflow), 1);
    chk("t2_req", 32'(bus.d_req), 1);
    chk("t2_nowrite", 32'(wl_a.size()), 32'(n0));
    bus.t_grant = 1'b0;
    wait_wr(n0 + 4, 40, "t2_wait");
    for (int j = 0; j < 4; j++) if (wl_a.size() > n0 + j) begin
      chk("t2_addr", 32'(wl_a[n0 + j]), 32'(j));
      chk("t2_data", 32'(wl_d[n0 + j]), 32'(j + 1));
    end
    bus.clr_overflow = 1'b1;
    cyc(); bus.clr_overflow = 1'b0; #1;
    chk("t2_ovf_clr", 32'(bus.overflow), 0);
    repeat (5) cyc();
    chk("t2_count", 32'(wl_a.size()), 32'(n0 + 4));

    // Two full frames plus one: bank wrap and frame_done.
    do_reset();
    n0 = wl_a.size(); f0 = fd_b.size();
    for (int i = 0; i < 129; i++) begin
      bus.s_valid = 1'b1; bus.s_data = 16'h1000 + 16'(i);
      cyc(); bus.s_valid = 1'b0; cyc(); cyc();
    end
    wait_wr(n0 + 129, 20, "t3_wait");
    if (wl_a.size() >= n0 + 129) begin
      chk("t3_addr63", 32'(wl_a[n0 + 63]), 32'h3F);
      chk("t3_addr64", 32'(wl_a[n0 + 64]), 32'h40);
      chk("t3_addr127", 32'(wl_a[n0 + 127]), 32'h7F);
      chk("t3_addr128", 32'(wl_a[n0 + 128]), 32'h00);
      chk("t3_data128", 32'(wl_d[n0 + 128]), 32'h1080);
    end
    chk("t3_fd_count", 32'(fd_b.size()), 32'(f0 + 2));
    if (fd_b.size() >= f0 + 2) begin
      chk("t3_fd_bank0", 32'(fd_b[f0]), 0);
      chk("t3_fd_bank1", 32'(fd_b[f0 + 1]), 1);
    end

    // Grant raised in the WRITE cycle: aborted, retried once.
    do_reset();
    n0 = wl_a.size();
    bus.s_valid = 1'b1; bus.s_data = 16'h1234;
    cyc(); bus.s_valid = 1'b0;
    cyc();
    cyc(); bus.t_grant = 1'b1; #1;
    chk("t4_abort_wr", 32'(bus.d_wr), 0);
    cyc(); cyc(); #1;
    chk("t4_req_held", 32'(bus.d_req), 1);
    chk("t4_nowrite", 32'(wl_a.size()), 32'(n0));
    bus.t_grant = 1'b0;
    wait_wr(n0 + 1, 10, "t4_wait");
    repeat (5) cyc();
    chk("t4_once", 32'(wl_a.size()), 32'(n0 + 1));
    if (wl_a.size() > n0) begin
      chk("t4_addr", 32'(wl_a[n0]), 32'h00);
      chk("t4_data", 32'(wl_d[n0]), 32'h1234);
    end

    // Reset during SETUP with two samples queued.
    do_reset();
    n0 = wl_a.size();
    bus.s_valid = 1'b1; bus.s_data = 16'hBEEF;
    cyc(); bus.s_data = 16'hCAFE;
    cyc(); bus.s_valid = 1'b0; reset = 1'b1;
    cyc(); reset = 1'b0; #1;
    chk("t5_req", 32'(bus.d_req), 0);
    chk("t5_wr", 32'(bus.d_wr), 0);
    chk("t5_addr", 32'(bus.d_addrs), 0);
    chk("t5_data", 32'(bus.d_datain), 0);
    chk("t5_ovf", 32'(bus.overflow), 0);
    chk("t5_fd", 32'(bus.frame_done), 0);
    chk("t5_bank", 32'(bus.bank), 0);
    repeat (8) cyc();
    chk("t5_nowrite", 32'(wl_a.size()), 32'(n0));
    bus.s_valid = 1'b1; bus.s_data = 16'h7777;
    cyc(); bus.s_valid = 1'b0;
    wait_wr(n0 + 1, 10, "t5_wait");
    if (wl_a.size() > n0) begin
      chk("t5_next_addr", 32'(wl_a[n0]), 32'h00);
      chk("t5_next_data", 32'(wl_d[n0]), 32'h7777);
    end

    // Push into a full FIFO during a committing pop: still dropped.
    do_reset();
    n0 = wl_a.size();
    bus.t_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 1'b1; bus.s_data = 16'h21 + 16'(i);
      cyc();
    end
    bus.s_valid = 1'b0; bus.t_grant = 1'b0;
    hit = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      cyc(); #1;
      if (bus.d_wr) begin
        hit = 1; bus.s_valid = 1'b1; bus.s_data = 16'h9999;
      end
    end
    chk("t6_found_write", 32'(hit), 1);
    cyc(); bus.s_valid = 1'b0; #1;
    chk("t6_ovf", 32'(bus.overflow), 1);
    wait_wr(n0 + 4, 30, "t6_wait");
    repeat (6) cyc();
    chk("t6_count", 32'(wl_a.size()), 32'(n0 + 4));
    for (int j = 0; j < 4; j++) if (wl_d.size() > n0 + j)
      chk("t6_data", 32'(wl_d[n0 + j]), 32'(16'h21 + 16'(j)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
